// File: rtl/uart_pkg.sv
// Purpose : shared UART definitions (receiver/transmitter state encoding, frame sizing).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t (IDLE, START, DATA, PARITY, STOP), DEFAULT_BAUD_DIV, DATA_BITS.
package uart_pkg;

    localparam int DEFAULT_BAUD_DIV = 2604;  // 50 MHz / 19200 baud
    localparam int DATA_BITS        = 8;

    // PARITY is only visited when the receiver is built with UART_RCV_PARITY_EN.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_sync2.sv
// Purpose : two-flop synchronizer for an async input plus a falling-edge detect.
// Latency : sync_o follows async_i after 2 clk; fall_o is high the cycle sync_o first reads 0.
// Backpressure: none; free-running.
// Ports   : clk, rst (sync, active-high; flops reset to 1 = idle line),
//           async_i (raw pin), sync_o (synchronized level), fall_o (1->0 on sync_o).
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;  // previous synchronized value, for edge detect

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync_o = s2_q;
    assign fall_o = s3_q & ~s2_q;

endmodule

// File: rtl/uart_rcv.sv
// Purpose : 8N1 UART receiver (8E1 when UART_RCV_PARITY_EN is defined), mid-bit sampling.
// Latency : rdy/rx_data update 1 clk after the stop-bit sample (3+HALF_DIV+9*BAUD_DIV+1 clk from pin fall in 8N1).
// Backpressure: none on the line; an unacknowledged byte is overwritten and flagged by overrun.
// Ports   : clk, rst (sync, active-high), RX (async, idle high), clr_rdy (clears rdy/overrun),
//           rx_data (last good byte), rdy (sticky), framing_err (pulse), overrun (sticky),
//           parity_err (pulse; tied 0 unless UART_RCV_PARITY_EN).
// Config  : `define UART_RCV_PARITY_EN for an even-parity bit between data and stop.
module uart_rcv
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       framing_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int HALF_DIV = BAUD_DIV / 2;

    logic        rx_s;
    logic        rx_fall;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [3:0]  bit_q;
    logic [7:0]  shift_q;
    logic [7:0]  data_q;
    logic        done_q;   // good frame sampled last cycle; commit it now
    logic        rdy_q;
    logic        ovr_q;
    logic        ferr_q;
`ifdef UART_RCV_PARITY_EN
    logic        par_q;      // running XOR of data bits
    logic        par_bad_q;  // parity bit disagreed with par_q
    logic        perr_q;
`endif

    logic tick;
    assign tick = (cnt_q == 16'd0);

    uart_sync2 u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (RX),
        .sync_o  (rx_s),
        .fall_o  (rx_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_q     <= 4'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            rdy_q     <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RCV_PARITY_EN
            par_q     <= 1'b0;
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RCV_PARITY_EN
            perr_q <= 1'b0;
`endif
            // A completing byte beats a same-cycle acknowledge.
            if (done_q) begin
                data_q <= shift_q;
                rdy_q  <= 1'b1;
                if (rdy_q) ovr_q <= 1'b1;
            end else if (clr_rdy) begin
                rdy_q <= 1'b0;
                ovr_q <= 1'b0;
            end

            if (!tick) cnt_q <= cnt_q - 16'd1;

            case (state_q)
                // The edge detector only fires on a real 1->0 transition, so a line
                // left low after a bad stop bit must go high before we re-arm.
                IDLE: begin
                    if (rx_fall) begin
                        state_q <= START;
                        cnt_q   <= 16'(HALF_DIV - 1);
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state_q <= DATA;
                            cnt_q   <= 16'(BAUD_DIV - 1);
                            bit_q   <= 4'd0;
`ifdef UART_RCV_PARITY_EN
                            par_q   <= 1'b0;
`endif
                        end else begin
                            state_q <= IDLE;  // start-bit glitch
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= {rx_s, shift_q[7:1]};  // LSB arrives first
                        cnt_q   <= 16'(BAUD_DIV - 1);
                        bit_q   <= (bit_q == 4'd8) ? 4'd8 : bit_q + 4'd1;
`ifdef UART_RCV_PARITY_EN
                        par_q   <= par_q ^ rx_s;
                        if (bit_q == 4'(DATA_BITS - 1)) state_q <= PARITY;
`else
                        if (bit_q == 4'(DATA_BITS - 1)) state_q <= STOP;
`endif
                    end
                end
`ifdef UART_RCV_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_bad_q <= par_q ^ rx_s;
                        cnt_q     <= 16'(BAUD_DIV - 1);
                        state_q   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
`ifdef UART_RCV_PARITY_EN
                        if (rx_s) begin
                            done_q <= ~par_bad_q;
                            perr_q <= par_bad_q;
                        end else begin
                            ferr_q <= 1'b1;  // framing wins over parity
                        end
`else
                        if (rx_s) done_q <= 1'b1;
                        else      ferr_q <= 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data     = data_q;
    assign rdy         = rdy_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;
`ifdef UART_RCV_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
